// File: rtl/commit_aggregator_mpu.sv
// commit_aggregator_mpu
//   Collects per-unit completion reports for every MPU issue number and
//   emits one commit per cycle toward the MPU commit table once all the
//   units named in the issue's participation mask have reported done.
//   Completed entries are committed in round-robin order.
//
// Entry states:
//   state | meaning
//   IDLE  | entry free, no issue outstanding
//   WAIT  | issued, at least one participating unit still pending
//   READY | all units reported, waiting for a commit grant
//
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   I_Req_Issue    dispatch registers issue I_Issue_No with mask I_Issue_Mask
//   I_Done         per-unit done strobe; unit u reports I_Done_No[u*WIDTH_NO +: WIDTH_NO]
//   O_Req_Commit   one-cycle commit pulse, O_Commit_No names the issue
//   O_Num_Pend     registered count of entries in WAIT or READY
//   O_Err          sticky protocol-error flag
module commit_aggregator_mpu #(
  parameter int NUM_UNIT  = 4,
  parameter int NUM_ENTRY = 16,
  parameter int WIDTH_NO  = $clog2(NUM_ENTRY)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         I_Req_Issue,
  input  logic [WIDTH_NO-1:0]          I_Issue_No,
  input  logic [NUM_UNIT-1:0]          I_Issue_Mask,
  input  logic [NUM_UNIT-1:0]          I_Done,
  input  logic [NUM_UNIT*WIDTH_NO-1:0] I_Done_No,
  output logic                         O_Req_Commit,
  output logic [WIDTH_NO-1:0]          O_Commit_No,
  output logic [WIDTH_NO:0]            O_Num_Pend,
  output logic                         O_Err
);

  typedef enum logic [1:0] {IDLE, WAIT, READY} entry_state_t;

  entry_state_t        state   [NUM_ENTRY];
  entry_state_t        state_n [NUM_ENTRY];
  logic [NUM_UNIT-1:0] pend    [NUM_ENTRY];
  logic [NUM_UNIT-1:0] pend_n  [NUM_ENTRY];
  logic [NUM_UNIT-1:0] clr     [NUM_ENTRY];
  logic [WIDTH_NO-1:0] ptr;
  logic [WIDTH_NO-1:0] scan_idx;
  logic [WIDTH_NO-1:0] grant_no;
  logic                found;
  logic                issue_hit;
  logic                err_now;
  logic [WIDTH_NO:0]   count_n;

  // Round-robin pick among entries that are READY in the current state, so
  // an entry turning READY at this edge is only grantable from the next one.
  // NUM_ENTRY is a power of two, so the index addition wraps by itself.
  always_comb begin
    found    = 1'b0;
    grant_no = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      scan_idx = ptr + WIDTH_NO'(i);
      if (!found && state[scan_idx] == READY) begin
        found    = 1'b1;
        grant_no = scan_idx;
      end
    end
  end

  // Per-entry next state. Offending events are dropped and flagged; an issue
  // and a done aimed at the same IDLE entry keep the issue and drop the done.
  always_comb begin
    err_now   = 1'b0;
    count_n   = '0;
    issue_hit = 1'b0;
    for (int e = 0; e < NUM_ENTRY; e++) begin
      state_n[e] = state[e];
      pend_n[e]  = pend[e];
      clr[e]     = '0;
      for (int u = 0; u < NUM_UNIT; u++) begin
        if (I_Done[u] && I_Done_No[u*WIDTH_NO +: WIDTH_NO] == WIDTH_NO'(e)) begin
          if (state[e] == WAIT && pend[e][u]) clr[e][u] = 1'b1;
          else                                err_now   = 1'b1;
        end
      end
      issue_hit = I_Req_Issue && (I_Issue_No == WIDTH_NO'(e));
      case (state[e])
        IDLE: begin
          if (issue_hit) begin
            if (|I_Issue_Mask) begin
              state_n[e] = WAIT;
              pend_n[e]  = I_Issue_Mask;
            end else begin
              state_n[e] = READY;
            end
          end
        end
        WAIT: begin
          if (issue_hit) err_now = 1'b1;
          pend_n[e] = pend[e] & ~clr[e];
          if (pend_n[e] == '0) state_n[e] = READY;
        end
        READY: begin
          if (issue_hit) err_now = 1'b1;
          if (found && grant_no == WIDTH_NO'(e)) state_n[e] = IDLE;
        end
        default: state_n[e] = IDLE;
      endcase
      if (state_n[e] != IDLE) count_n = count_n + (WIDTH_NO+1)'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        state[e] <= IDLE;
        pend[e]  <= '0;
      end
      ptr          <= '0;
      O_Req_Commit <= 1'b0;
      O_Commit_No  <= '0;
      O_Num_Pend   <= '0;
      O_Err        <= 1'b0;
    end else begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        state[e] <= state_n[e];
        pend[e]  <= pend_n[e];
      end
      O_Num_Pend   <= count_n;
      O_Err        <= O_Err | err_now;
      O_Req_Commit <= found;
      if (found) begin
        O_Commit_No <= grant_no;
        ptr         <= grant_no + WIDTH_NO'(1);
      end
    end
  end

endmodule

// File: tb/tb_commit_aggregator_mpu.sv
// Directed bench for commit_aggregator_mpu: a table of per-edge vectors for
// the normal flows, then hand-written sequences for ordering, errors and reset.
module tb_commit_aggregator_mpu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_issue;
  logic [3:0]  issue_no;
  logic [3:0]  issue_mask;
  logic [3:0]  done;
  logic [15:0] done_no;
  logic        req_commit;
  logic [3:0]  commit_no;
  logic [4:0]  num_pend;
  logic        err;

  int tests = 0;
  int fails = 0;

  commit_aggregator_mpu dut (
    .clock        (clock),
    .reset        (reset),
    .I_Req_Issue  (req_issue),
    .I_Issue_No   (issue_no),
    .I_Issue_Mask (issue_mask),
    .I_Done       (done),
    .I_Done_No    (done_no),
    .O_Req_Commit (req_commit),
    .O_Commit_No  (commit_no),
    .O_Num_Pend   (num_pend),
    .O_Err        (err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        iss;
    logic [3:0]  ino;
    logic [3:0]  imask;
    logic [3:0]  done;
    logic [15:0] dno;
    logic        ereq;
    logic [3:0]  eno;
    logic [4:0]  epend;
    logic        eerr;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tbl [NVEC];

  function automatic vec_t mk(logic iss, logic [3:0] ino, logic [3:0] imask,
                              logic [3:0] dn, logic [15:0] dno,
                              logic ereq, logic [3:0] eno, logic [4:0] epend,
                              logic eerr);
    vec_t v;
    v.iss = iss; v.ino = ino; v.imask = imask; v.done = dn; v.dno = dno;
    v.ereq = ereq; v.eno = eno; v.epend = epend; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic ereq, input logic [3:0] eno,
                           input logic [4:0] epend, input logic eerr);
    check({tag, ".req"},  32'(req_commit), 32'(ereq));
    check({tag, ".no"},   32'(commit_no),  32'(eno));
    check({tag, ".pend"}, 32'(num_pend),   32'(epend));
    check({tag, ".err"},  32'(err),        32'(eerr));
  endtask

  // Apply inputs at the falling edge, sample one step after the rising edge.
  task automatic drive(input logic iss, input logic [3:0] ino, input logic [3:0] imask,
                       input logic [3:0] dn, input logic [15:0] dno);
    @(negedge clock);
    req_issue = iss; issue_no = ino; issue_mask = imask; done = dn; done_no = dno;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 4'd0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req_issue = 1'b0; issue_no = '0; issue_mask = '0; done = '0; done_no = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // ptr 0: three single-unit issues completing one per edge -> 2,7,9 back to back
    tbl[0]  = mk(1, 4'd2,  4'b0001, 4'b0000, 16'h0000, 0, 4'd0,  5'd1, 0);
    tbl[1]  = mk(1, 4'd7,  4'b0001, 4'b0000, 16'h0000, 0, 4'd0,  5'd2, 0);
    tbl[2]  = mk(1, 4'd9,  4'b0001, 4'b0000, 16'h0000, 0, 4'd0,  5'd3, 0);
    tbl[3]  = mk(0, 4'd0,  4'b0000, 4'b0001, 16'h0002, 0, 4'd0,  5'd3, 0);
    tbl[4]  = mk(0, 4'd0,  4'b0000, 4'b0001, 16'h0007, 1, 4'd2,  5'd2, 0);
    tbl[5]  = mk(0, 4'd0,  4'b0000, 4'b0001, 16'h0009, 1, 4'd7,  5'd1, 0);
    tbl[6]  = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 1, 4'd9,  5'd0, 0);
    tbl[7]  = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 0, 4'd9,  5'd0, 0);
    // issue 3 mask 0101, u0 done, u2 done two edges later
    tbl[8]  = mk(1, 4'd3,  4'b0101, 4'b0000, 16'h0000, 0, 4'd9,  5'd1, 0);
    tbl[9]  = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 0, 4'd9,  5'd1, 0);
    tbl[10] = mk(0, 4'd0,  4'b0000, 4'b0001, 16'h0003, 0, 4'd9,  5'd1, 0);
    tbl[11] = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 0, 4'd9,  5'd1, 0);
    tbl[12] = mk(0, 4'd0,  4'b0000, 4'b0100, 16'h0300, 0, 4'd9,  5'd1, 0);
    tbl[13] = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 1, 4'd3,  5'd0, 0);
    tbl[14] = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 0, 4'd3,  5'd0, 0);
    // zero-mask issue 5
    tbl[15] = mk(1, 4'd5,  4'b0000, 4'b0000, 16'h0000, 0, 4'd3,  5'd1, 0);
    tbl[16] = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 1, 4'd5,  5'd0, 0);
    tbl[17] = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 0, 4'd5,  5'd0, 0);
    // all four units done for entry 1 in the same edge
    tbl[18] = mk(1, 4'd1,  4'b1111, 4'b0000, 16'h0000, 0, 4'd5,  5'd1, 0);
    tbl[19] = mk(0, 4'd0,  4'b0000, 4'b1111, 16'h1111, 0, 4'd5,  5'd1, 0);
    tbl[20] = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 1, 4'd1,  5'd0, 0);
    tbl[21] = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 0, 4'd1,  5'd0, 0);
    // issue 13 and done u1 for entry 12 in the same edge; ptr=2 picks 12 first
    tbl[22] = mk(1, 4'd12, 4'b0010, 4'b0000, 16'h0000, 0, 4'd1,  5'd1, 0);
    tbl[23] = mk(1, 4'd13, 4'b0000, 4'b0010, 16'h00C0, 0, 4'd1,  5'd2, 0);
    tbl[24] = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 1, 4'd12, 5'd1, 0);
    tbl[25] = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 1, 4'd13, 5'd0, 0);
    tbl[26] = mk(0, 4'd0,  4'b0000, 4'b0000, 16'h0000, 0, 4'd13, 5'd0, 0);

    reset = 1'b1;
    req_issue = 1'b0; issue_no = '0; issue_mask = '0; done = '0; done_no = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_out("reset", 0, 4'd0, 5'd0, 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].iss, tbl[i].ino, tbl[i].imask, tbl[i].done, tbl[i].dno);
      check_out($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].eno, tbl[i].epend, tbl[i].eerr);
    end

    // Round-robin from ptr=8 with 2 and 9 ready together -> 9 then 2.
    // ptr is 14 here; committing entry 7 moves it to 8.
    drive(1, 4'd7, 4'b0000, 4'b0000, 16'h0000);
    idle();
    check_out("rr_c7", 1, 4'd7, 5'd0, 0);
    drive(1, 4'd2, 4'b0001, 4'b0000, 16'h0000);
    drive(1, 4'd9, 4'b0010, 4'b0000, 16'h0000);
    drive(0, 4'd0, 4'b0000, 4'b0011, 16'h0092);
    check_out("rr_rdy", 0, 4'd7, 5'd2, 0);
    idle();
    check_out("rr_c9", 1, 4'd9, 5'd1, 0);
    idle();
    check_out("rr_c2", 1, 4'd2, 5'd0, 0);
    idle();
    check_out("rr_end", 0, 4'd2, 5'd0, 0);

    // Done to an IDLE entry: sticky error, entry 6 remains usable.
    drive(0, 4'd0, 4'b0000, 4'b0010, 16'h0060);
    check_out("err_idle", 0, 4'd2, 5'd0, 1);
    idle();
    check("err_sticky", 32'(err), 32'd1);
    drive(1, 4'd6, 4'b0000, 4'b0000, 16'h0000);
    idle();
    check_out("e6_commit", 1, 4'd6, 5'd0, 1);

    // Issue to a WAIT entry: flagged, original pend mask kept.
    do_reset();
    drive(1, 4'd4, 4'b0011, 4'b0000, 16'h0000);
    check_out("w4_issue", 0, 4'd0, 5'd1, 0);
    drive(1, 4'd4, 4'b0100, 4'b0000, 16'h0000);
    check_out("w4_reissue", 0, 4'd0, 5'd1, 1);
    drive(0, 4'd0, 4'b0000, 4'b0011, 16'h0044);
    idle();
    check_out("w4_commit", 1, 4'd4, 5'd0, 1);

    // Done to the entry being issued in the same edge: done dropped, issue kept.
    do_reset();
    drive(1, 4'd10, 4'b0001, 4'b0001, 16'h000A);
    check_out("dbi", 0, 4'd0, 5'd1, 1);
    idle();
    check_out("dbi_wait", 0, 4'd0, 5'd1, 1);
    drive(0, 4'd0, 4'b0000, 4'b0001, 16'h000A);
    idle();
    check_out("dbi_commit", 1, 4'd10, 5'd0, 1);

    // Asynchronous reset mid-cycle with three WAIT and one READY entry.
    do_reset();
    drive(1, 4'd0, 4'b0001, 4'b1000, 16'hF000);
    drive(1, 4'd1, 4'b0001, 4'b0000, 16'h0000);
    drive(1, 4'd2, 4'b0001, 4'b0000, 16'h0000);
    drive(1, 4'd3, 4'b0000, 4'b0000, 16'h0000);
    check_out("pre_rst", 0, 4'd0, 5'd4, 1);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_rst", 0, 4'd0, 5'd0, 0);
    req_issue = 1'b0; issue_no = '0; issue_mask = '0; done = '0; done_no = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      check_out($sformatf("post_rst%0d", i), 0, 4'd0, 5'd0, 0);
    end
    drive(1, 4'd0, 4'b0000, 4'b0000, 16'h0000);
    check_out("fresh_rdy", 0, 4'd0, 5'd1, 0);
    idle();
    check_out("fresh_commit", 1, 4'd0, 5'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
